// File: rtl/mul_32_seq.sv
// mul_32_seq: iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Signed operands are reduced to magnitudes. The sign is reapplied in a single
// fix-up cycle. The result is returned as HI/LO halves.
module mul_32_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] T,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y_hi,
    output logic [WIDTH-1:0] Y_lo
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_mcand;   // multiplicand, pre-shifted left by r_cnt
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;  // multiplier, consumed LSB-first
    logic               r_neg;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_y_hi;
    logic [WIDTH-1:0]   r_y_lo;

    logic [WIDTH-1:0]   w_s_mag;
    logic [WIDTH-1:0]   w_t_mag;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_result;

    // Operand magnitudes. The most negative value negates to itself, and that is
    // its correct unsigned magnitude.
    always_comb begin
        w_s_mag = (signed_op && S[WIDTH-1]) ? (~S + WIDTH'(1)) : S;
        w_t_mag = (signed_op && T[WIDTH-1]) ? (~T + WIDTH'(1)) : T;
    end

    // One partial product per iteration. The final sign is applied in FIX.
    always_comb begin
        w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_result   = r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_y_hi   <= '0;
            r_y_lo   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_s_mag};
                        r_mplier <= w_t_mag;
                        r_neg    <= signed_op & (S[WIDTH-1] ^ T[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT)
                        r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_y_hi  <= w_result[2*WIDTH-1:WIDTH];
                    r_y_lo  <= w_result[WIDTH-1:0];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign Y_hi = r_y_hi;
    assign Y_lo = r_y_lo;

endmodule

// File: tb/tb_mul_32_seq.sv
// tb_mul_32_seq: table-driven and scoreboard-based check of mul_32_seq.
module tb_mul_32_seq;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] t;
        logic         sg;
        logic [W-1:0] e_hi;
        logic [W-1:0] e_lo;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         signed_op;
    logic [W-1:0] S;
    logic [W-1:0] T;
    logic         busy;
    logic         done;
    logic [W-1:0] Y_hi;
    logic [W-1:0] Y_lo;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    mul_32_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .start    (start),
        .signed_op(signed_op),
        .S        (S),
        .T        (T),
        .busy     (busy),
        .done     (done),
        .Y_hi     (Y_hi),
        .Y_lo     (Y_lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent reference: a 64-bit multiply of sign- or zero-extended operands.
    function automatic exp_t model(input logic [W-1:0] s, input logic [W-1:0] t, input logic sg);
        logic [63:0] a, b, p;
        exp_t e;
        a = sg ? {{W{s[W-1]}}, s} : {{W{1'b0}}, s};
        b = sg ? {{W{t[W-1]}}, t} : {{W{1'b0}}, t};
        p = a * b;
        e.hi = p[63:32];
        e.lo = p[31:0];
        return e;
    endfunction

    // Drive a one-cycle start and push the expected result to the scoreboard.
    task automatic issue(input logic [W-1:0] s, input logic [W-1:0] t, input logic sg, input exp_t e);
        start = 1'b1; S = s; T = t; signed_op = sg;
        sb_q.push_back(e);
        tick();
        start = 1'b0;
    endtask

    // Wait for done within a bound. Return the number of edges and whether busy stayed high.
    task automatic wait_done(output int cyc, output bit busy_ok);
        cyc = 0;
        busy_ok = 1'b1;
        while (!done && cyc < 80) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: done not seen within %0d cycles", cyc);
        end
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty at done", name);
        end else begin
            e = sb_q.pop_front();
            check(name, {Y_hi, Y_lo}, {e.hi, e.lo});
        end
    endtask

    task automatic full_op(input string name, input logic [W-1:0] s, input logic [W-1:0] t,
                           input logic sg, input exp_t e);
        int cyc;
        bit bok;
        issue(s, t, sg, e);
        check({name, "_busy"}, 64'(busy), 64'd1);
        wait_done(cyc, bok);
        check({name, "_lat"}, 64'(cyc), 64'(LAT));
        check({name, "_busyhold"}, 64'(bok), 64'd1);
        pop_check(name);
    endtask

    initial begin
        int   cyc;
        bit   bok;
        bit   saw_done;
        exp_t e;
        vec_t v;

        vecs.push_back('{32'd7,        32'd6,        1'b1, 32'h00000000, 32'h0000002A});
        vecs.push_back('{32'hFFFFFFFD, 32'd5,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001});
        vecs.push_back('{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000});
        vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000});
        vecs.push_back('{32'h00000000, 32'h12345678, 1'b1, 32'h00000000, 32'h00000000});
        vecs.push_back('{32'h80000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'h80000000});
        vecs.push_back('{32'h7FFFFFFF, 32'h80000000, 1'b1, 32'hC0000000, 32'h80000000});

        rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; S = '0; T = '0;
        tick(); tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_y", {Y_hi, Y_lo}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Table vectors with constant expectations.
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            e.hi = v.e_hi;
            e.lo = v.e_lo;
            full_op($sformatf("vec%0d", i), v.s, v.t, v.sg, e);
            tick();
        end

        // Random operands checked against the reference model.
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] rs, rt;
            logic rsg;
            rs  = $urandom;
            rt  = $urandom;
            rsg = 1'($urandom_range(0, 1));
            full_op($sformatf("rnd%0d", i), rs, rt, rsg, model(rs, rt, rsg));
        end
        tick();

        // Handshake: a start while busy is ignored, and a start in the done cycle is accepted.
        e.hi = 0; e.lo = 12;
        issue(32'd3, 32'd4, 1'b0, e);
        for (int i = 0; i < 8; i++) tick();
        start = 1'b1; S = 32'd9; T = 32'd9;
        tick();
        start = 1'b0; S = 32'd1; T = 32'd1;
        wait_done(cyc, bok);
        check("hs_lat", 64'(cyc + 9), 64'(LAT));
        pop_check("hs_ignore");
        e.hi = 0; e.lo = 10;
        issue(32'd2, 32'd5, 1'b1, e);
        check("hs_b2b_busy", 64'(busy), 64'd1);
        check("hs_b2b_done_clr", 64'(done), 64'd0);
        check("hs_y_hold", {Y_hi, Y_lo}, 64'd12);
        wait_done(cyc, bok);
        check("hs_b2b_lat", 64'(cyc), 64'(LAT));
        pop_check("hs_b2b");
        tick();
        check("done_pulse", 64'(done), 64'd0);

        // Reset in the middle of an operation.
        e.hi = 0; e.lo = 42;
        full_op("pre_rst", 32'd7, 32'd6, 1'b0, e);
        tick();
        e = model(32'd5, 32'd5, 1'b0);
        issue(32'd5, 32'd5, 1'b0, e);
        for (int i = 0; i < 13; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb_q.delete();
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_y", {Y_hi, Y_lo}, 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        check("mid_rst_nodone", 64'(saw_done), 64'd0);
        check("mid_rst_y_stay", {Y_hi, Y_lo}, 64'd0);
        full_op("post_rst", 32'hFFFFFFFD, 32'd5, 1'b1, model(32'hFFFFFFFD, 32'd5, 1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
